stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumer end of the 50 MHz→100 Hz divider interface.
- Takes the divider's CLK_100Hz square wave as data and synchronises it into the CLK_50_MHz domain.
- Turns each CLK_100Hz rising edge into a one-cycle count enable.
- Runs a BCD stopwatch (MM:SS.cc) under a start/stop/lap/clear control FSM; outputs feed the 7-segment display driver.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on CLK_100Hz (legal range 2–3).
- MIN_WRAP, 59, last minute value before minutes wrap to 00 (BCD-decoded, 1–59).

Ports:
- CLK_50_MHz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- CLK_100Hz  in  1  100 Hz square wave from divider; asynchronous to this block's logic.
- start_stop  in  1  debounced level; its rising edge toggles run/pause.
- lap  in  1  debounced level; its rising edge toggles display freeze.
- clear  in  1  debounced level; its rising edge zeroes counters when paused.
- cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens  out  4 each  displayed BCD digits.
- running  out  1  high in RUN or LAP.
- lap_hold  out  1  high in LAP.
- rollover  out  1  one-cycle pulse when the count wraps to 00:00.00.

Behaviour:
- Reset (async assert, sync release):
  - all counters, digit outputs, running, lap_hold, rollover = 0;
  - state = IDLE;
  - synchroniser and button edge registers = 0.
- Tick generation:
  - CLK_100Hz passes through SYNC_STAGES flops, then one history flop.
  - tick = synced & ~history.
  - With SYNC_STAGES=2, the counter updates on the 3rd CLK_50_MHz rising edge after CLK_100Hz rises (setup met).
  - Exactly one tick per CLK_100Hz period.
- Button inputs: each has a registered previous value; edge = in & ~prev (one cycle). Levels held high generate no further edges.
- FSM states (IDLE, RUN, PAUSE, LAP):
  - IDLE: start_stop → RUN.
  - RUN: start_stop → PAUSE; lap → LAP (display registers capture live count).
  - LAP: lap → RUN; start_stop → PAUSE, and display returns to live count.
  - PAUSE: clear → IDLE and zero all counters; otherwise start_stop → RUN.
  - clear is ignored in IDLE, RUN and LAP; lap is ignored in IDLE and PAUSE.
- Simultaneous events:
  - Priority in PAUSE: clear > start_stop.
  - Priority in RUN/LAP: start_stop > lap.
  - Counting is qualified by the registered state in the same cycle as the tick. A tick coinciding with the start_stop edge that leaves RUN is still counted; a tick coinciding with the edge that enters RUN is not.
- Counting (when tick and state ∈ {RUN, LAP}):
  - cs_ones 0–9, carry into cs_tens 0–9;
  - carry into sec_ones 0–9, then sec_tens 0–5;
  - carry into minutes, which wrap after MIN_WRAP to 00.
  - Full wrap 59:59.99 → 00:00.00 asserts rollover for that one cycle.
  - Digits never leave BCD range.
- Display:
  - Outputs are registered.
  - Outside LAP they follow the live count with 1 cycle latency.
  - In LAP they hold the value captured at LAP entry.
- Reset mid-count: immediate asynchronous zeroing; the next tick after release is ignored unless the FSM has reached RUN.

Optional Feature:
- Macro: STOPWATCH_HOURS_EN.
- Defined:
  - adds output hr_ones (4 bits, 0–9);
  - minutes always wrap at 59 and carry into hours;
  - rollover fires on 9:59:59.99 → 0:00:00.00.
- Undefined: no hr_ones port; minutes wrap at MIN_WRAP as above.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE, LAP);
  - BCD digit type (4 bits);
  - limit constants CS_MAX=9, SEC_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module bcd_digit_counter:
  - parameter MAX;
  - inputs: en, clr;
  - outputs: q, carry_out (= en & q==MAX).
  - Chained six (seven with hours) times.

Test Plan:
- Reset held 20 ns, then CLK_100Hz toggling at 5 ms half-period, start_stop never pressed → all digits stay 0, running=0.
- start_stop pulse, run 1.5 s → display reads 00:01.50 ±1 cs; each increment lands on the 3rd CLK_50_MHz edge after CLK_100Hz rises.
- RUN, lap at 00:00.40, lap again after 0.3 s → display frozen at 00:00.40, then jumps to 00:00.70 one cycle after the second lap edge.
- PAUSE, then clear and start_stop in the same cycle → state IDLE, digits 00:00.00, running=0.
- Force count to 59:59.98 (via hierarchical deposit or a long run), two ticks → 59:59.99, then 00:00.00 with rollover high exactly one cycle.
- Assert reset for 100 ns at 00:12.34 while running → outputs 0 asynchronously; after release, ticks ignored until start_stop.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int CS_MAX       = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  // The count advances only while the stopwatch is live (LAP keeps counting behind the frozen display).
  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit counting 0..MAX, with synchronous clear taking priority over enable.
// Latency: q updates on the clock edge after en; carry_out is combinational (en while q==MAX).
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry_out
);

  localparam logic [3:0] LP_MAX = 4'(MAX);

  bcd_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= (r_q == LP_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q         = r_q;
  assign carry_out = en & (r_q == LP_MAX);

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch MM:SS.cc fed by an asynchronous 100 Hz wave; STOPWATCH_HOURS_EN adds an hours digit.
// Latency: count moves 3 clocks after the wave rises, display follows 1 clock later; no backpressure.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WRAP    = 59
) (
  input  logic       CLK_50_MHz,
  input  logic       reset,
  input  logic       CLK_100Hz,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
`ifdef STOPWATCH_HOURS_EN
  output logic [3:0] hr_ones,
`endif
  output logic       running,
  output logic       lap_hold,
  output logic       rollover
);

`ifdef STOPWATCH_HOURS_EN
  localparam int LP_MIN_LAST = 59;
`else
  localparam int LP_MIN_LAST = MIN_WRAP;
`endif
  localparam logic [3:0] LP_MIN_TENS_LAST = 4'(LP_MIN_LAST / 10);
  localparam logic [3:0] LP_MIN_ONES_LAST = 4'(LP_MIN_LAST % 10);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_ss_prev;
  logic                   r_lap_prev;
  logic                   r_clr_prev;
  state_t                 r_state;
  logic                   r_running;
  logic                   r_lap_hold;
  logic                   r_rollover;

  logic w_tick;
  logic w_ss_edge;
  logic w_lap_edge;
  logic w_clr_edge;
  logic w_count_en;
  logic w_clear_cnt;
  logic w_hold;

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_hist     <= 1'b0;
      r_ss_prev  <= 1'b0;
      r_lap_prev <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], CLK_100Hz};
      r_hist     <= r_sync[SYNC_STAGES-1];
      r_ss_prev  <= start_stop;
      r_lap_prev <= lap;
      r_clr_prev <= clear;
    end
  end

  assign w_tick     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_ss_edge  = start_stop & ~r_ss_prev;
  assign w_lap_edge = lap & ~r_lap_prev;
  assign w_clr_edge = clear & ~r_clr_prev;

  // Qualified by the state before this edge, so the tick that leaves RUN still counts.
  assign w_count_en  = w_tick & is_counting(r_state);
  assign w_clear_cnt = (r_state == PAUSE) & w_clr_edge;
  assign w_hold      = (r_state == LAP) & ~w_ss_edge & ~w_lap_edge;

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ss_edge) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_ss_edge) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (w_lap_edge) begin
            r_state    <= LAP;
            r_lap_hold <= 1'b1;
          end
        end
        LAP: begin
          if (w_ss_edge) begin
            r_state    <= PAUSE;
            r_running  <= 1'b0;
            r_lap_hold <= 1'b0;
          end else if (w_lap_edge) begin
            r_state    <= RUN;
            r_lap_hold <= 1'b0;
          end
        end
        PAUSE: begin
          if (w_clr_edge) begin
            r_state <= IDLE;
          end else if (w_ss_edge) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_running  <= 1'b0;
          r_lap_hold <= 1'b0;
        end
      endcase
    end
  end

  bcd_t w_cs_ones, w_cs_tens, w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
  logic w_cs_ones_co, w_cs_tens_co, w_sec_ones_co, w_sec_tens_co, w_min_ones_co;
  logic w_min_tens_co_unused;
  logic w_min_wrap;
  logic w_min_clr;
  logic w_wrap;

  bcd_digit_counter #(.MAX(CS_MAX)) u_cs_ones (
    .clk(CLK_50_MHz), .rst(reset), .en(w_count_en), .clr(w_clear_cnt),
    .q(w_cs_ones), .carry_out(w_cs_ones_co)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_tens (
    .clk(CLK_50_MHz), .rst(reset), .en(w_cs_ones_co), .clr(w_clear_cnt),
    .q(w_cs_tens), .carry_out(w_cs_tens_co)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(CLK_50_MHz), .rst(reset), .en(w_cs_tens_co), .clr(w_clear_cnt),
    .q(w_sec_ones), .carry_out(w_sec_ones_co)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(CLK_50_MHz), .rst(reset), .en(w_sec_ones_co), .clr(w_clear_cnt),
    .q(w_sec_tens), .carry_out(w_sec_tens_co)
  );

  // Minutes wrap on the decoded last value, which need not be a digit boundary.
  assign w_min_wrap = w_sec_tens_co & (w_min_tens == LP_MIN_TENS_LAST)
                                    & (w_min_ones == LP_MIN_ONES_LAST);
  assign w_min_clr  = w_clear_cnt | w_min_wrap;

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(CLK_50_MHz), .rst(reset), .en(w_sec_tens_co & ~w_min_wrap), .clr(w_min_clr),
    .q(w_min_ones), .carry_out(w_min_ones_co)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_min_tens (
    .clk(CLK_50_MHz), .rst(reset), .en(w_min_ones_co), .clr(w_min_clr),
    .q(w_min_tens), .carry_out(w_min_tens_co_unused)
  );

`ifdef STOPWATCH_HOURS_EN
  bcd_t w_hr_ones;
  logic r_hr_ones;
  logic [3:0] r_disp_hr_ones;

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_hr_ones (
    .clk(CLK_50_MHz), .rst(reset), .en(w_min_wrap), .clr(w_clear_cnt),
    .q(w_hr_ones), .carry_out(w_wrap)
  );

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      r_disp_hr_ones <= '0;
    end else if (!w_hold) begin
      r_disp_hr_ones <= w_hr_ones;
    end
  end

  assign hr_ones = r_disp_hr_ones;
`else
  assign w_wrap = w_min_wrap;
`endif

  bcd_t r_disp_cs_ones, r_disp_cs_tens, r_disp_sec_ones;
  bcd_t r_disp_sec_tens, r_disp_min_ones, r_disp_min_tens;

  // Entering LAP captures the pre-increment live count; leaving LAP resumes following it.
  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      r_disp_cs_ones  <= '0;
      r_disp_cs_tens  <= '0;
      r_disp_sec_ones <= '0;
      r_disp_sec_tens <= '0;
      r_disp_min_ones <= '0;
      r_disp_min_tens <= '0;
      r_rollover      <= 1'b0;
    end else begin
      if (!w_hold) begin
        r_disp_cs_ones  <= w_cs_ones;
        r_disp_cs_tens  <= w_cs_tens;
        r_disp_sec_ones <= w_sec_ones;
        r_disp_sec_tens <= w_sec_tens;
        r_disp_min_ones <= w_min_ones;
        r_disp_min_tens <= w_min_tens;
      end
      r_rollover <= w_wrap;
    end
  end

  assign cs_ones  = r_disp_cs_ones;
  assign cs_tens  = r_disp_cs_tens;
  assign sec_ones = r_disp_sec_ones;
  assign sec_tens = r_disp_sec_tens;
  assign min_ones = r_disp_min_ones;
  assign min_tens = r_disp_min_tens;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: random wave/button stimulus against a centisecond-count reference model.
module tb_stopwatch_core;

  localparam int MIN_WRAP = 1;
  localparam int LIMIT    = (MIN_WRAP + 1) * 6000;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic wave = 1'b0;
  logic ss   = 1'b0;
  logic lp   = 1'b0;
  logic cl   = 1'b0;
  logic fast = 1'b0;

  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_hold, rollover;

  int checks    = 0;
  int errors    = 0;
  int m_wraps   = 0;
  int dut_rolls = 0;

  logic [26:0] exp_q[$];

  stopwatch_core #(.SYNC_STAGES(2), .MIN_WRAP(MIN_WRAP)) dut (
    .CLK_50_MHz(clk),
    .reset(rst),
    .CLK_100Hz(wave),
    .start_stop(ss),
    .lap(lp),
    .clear(cl),
    .cs_ones(cs_ones),
    .cs_tens(cs_tens),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .min_ones(min_ones),
    .min_tens(min_tens),
    .running(running),
    .lap_hold(lap_hold),
    .rollover(rollover)
  );

  initial forever #10 clk = ~clk;

  initial begin
    forever begin
      if (fast) repeat (1) @(negedge clk);
      else repeat ($urandom_range(1, 4)) @(negedge clk);
      wave = ~wave;
    end
  end

  function automatic logic [23:0] digits(input int t);
    int mins;
    int secs;
    int c;
    mins = t / 6000;
    secs = (t / 100) % 60;
    c    = t % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] disp_now();
    return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Reference model: elapsed centiseconds as one integer, modes 0=idle 1=run 2=pause 3=lap.
  initial begin
    int   m_t;
    int   m_mode;
    logic [23:0] m_disp;
    logic m_roll, ss_p, lp_p, cl_p, w1, w2, w3;
    logic ss_e, lp_e, cl_e, tick, live, hold;
    m_t = 0; m_mode = 0; m_disp = '0; m_roll = 0;
    ss_p = 0; lp_p = 0; cl_p = 0; w1 = 0; w2 = 0; w3 = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0; m_mode = 0; m_disp = '0; m_roll = 0;
        ss_p = 0; lp_p = 0; cl_p = 0; w1 = 0; w2 = 0; w3 = 0;
        exp_q.push_back(27'd0);
      end else begin
        ss_e = ss & ~ss_p;
        lp_e = lp & ~lp_p;
        cl_e = cl & ~cl_p;
        // The wave's rise moves the count on the third clock edge after it is first sampled high.
        tick = w2 & ~w3;
        live = (m_mode == 1) || (m_mode == 3);
        hold = (m_mode == 3) && !ss_e && !lp_e;
        if (!hold) m_disp = digits(m_t);
        m_roll = tick && live && (m_t == LIMIT - 1);
        if (m_roll) m_wraps++;
        if (m_mode == 2 && cl_e) m_t = 0;
        else if (tick && live) m_t = (m_t + 1) % LIMIT;
        case (m_mode)
          0: if (ss_e) m_mode = 1;
          1: if (ss_e) m_mode = 2; else if (lp_e) m_mode = 3;
          3: if (ss_e) m_mode = 2; else if (lp_e) m_mode = 1;
          default: if (cl_e) m_mode = 0; else if (ss_e) m_mode = 1;
        endcase
        exp_q.push_back({m_disp, logic'((m_mode == 1) || (m_mode == 3)), logic'(m_mode == 3), m_roll});
        w3 = w2; w2 = w1; w1 = wave;
        ss_p = ss; lp_p = lp; cl_p = cl;
      end
    end
  end

  initial forever begin
    @(posedge rst);
    exp_q.delete();
  end

  initial begin
    logic [26:0] want;
    logic [26:0] got;
    forever begin
      @(negedge clk);
      if (rollover === 1'b1) dut_rolls++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {disp_now(), running, lap_hold, rollover};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard at %0t: got %h expected %h", $time, got, want);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic l, input logic c, input int len);
    @(negedge clk);
    ss = s; lp = l; cl = c;
    repeat (len) @(negedge clk);
    ss = 0; lp = 0; cl = 0;
  endtask

  initial begin
    int unsigned pick;
    @(negedge clk);
    rst = 1'b0;

    cycles(150);
    chk("idle_digits", 32'(disp_now()), 32'd0);
    chk("idle_running", 32'(running), 32'd1 - 32'd1);

    press(1, 0, 0, 1);
    cycles(300);
    chk("run_running", 32'(running), 32'd1);

    press(0, 1, 0, 1);
    cycles(2);
    chk("lap_entered", 32'(lap_hold), 32'd1);
    cycles(150);
    press(0, 1, 0, 1);
    cycles(2);
    chk("lap_released", 32'(lap_hold), 32'd0);
    cycles(100);

    press(1, 0, 0, 1);
    cycles(20);
    chk("paused_running", 32'(running), 32'd0);
    press(1, 0, 1, 1);
    cycles(2);
    chk("clear_digits", 32'(disp_now()), 32'd0);
    chk("clear_running", 32'(running), 32'd0);
    chk("clear_lap_hold", 32'(lap_hold), 32'd0);

    press(1, 0, 0, 1);
    cycles(60);
    press(0, 0, 1, 2);
    cycles(40);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 7);
      cycles($urandom_range(3, 60));
      press(pick[0], pick[1], pick[2], $urandom_range(1, 4));
    end

    @(posedge clk);
    #1 rst = 1'b1;
    cycles(2);
    rst  = 1'b0;
    fast = 1'b1;
    press(1, 0, 0, 1);
    for (int i = 0; i < 30000 && m_wraps == 0; i++) @(negedge clk);
    cycles(5);
    checks++;
    if (m_wraps == 0) begin
      errors++;
      $display("FAIL wrap_timeout: no wrap within cycle budget");
    end
    chk("rollover_pulses", 32'(dut_rolls), 32'(m_wraps));

    fast = 1'b0;
    cycles(300);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("async_zero", {5'd0, disp_now(), running, lap_hold, rollover}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    cycles(200);
    chk("post_reset_digits", 32'(disp_now()), 32'd0);
    chk("post_reset_running", 32'(running), 32'd0);
    press(1, 0, 0, 1);
    cycles(200);
    chk("restart_running", 32'(running), 32'd1);
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
